// File: rtl/t07_wire_game_ctrl.sv
// Round sequencer for the wire mini-game: draws wire count and target from an
// LFSR, judges SELECT presses against the locator cursor, tracks strikes/rounds.
module t07_wire_game_ctrl #(
  parameter int         ROUNDS      = 2,
  parameter int         MAX_STRIKES = 3,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] playing_state_in,
  input  logic       strobe,
  input  logic [5:0] button,
  input  logic [2:0] wire_pos,
  output logic [2:0] wire_num,
  output logic [2:0] target_wire,
  output logic [5:0] cut_mask,
  output logic [1:0] strikes,
  output logic [1:0] round_cnt,
  output logic       strike_pulse,
  output logic       wire_cleared,
  output logic       wire_failed
);

  localparam logic [2:0] WIRE      = 3'b010;
  localparam logic [5:0] SELECT    = 6'b000001;
  localparam logic [1:0] ROUNDS_W  = 2'(ROUNDS);
  localparam logic [1:0] STRIKES_W = 2'(MAX_STRIKES);

  typedef enum logic [2:0] {IDLE, GEN, ARMED, DONE, FAIL} state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [2:0] gen_num;
  logic [2:0] gen_t0;
  logic [2:0] gen_t1;
  logic [2:0] gen_tgt;
  logic [5:0] pos_bit;
  logic       pos_valid;
  logic       pos_cut;
  logic       in_wire;
  logic       select_hit;
  logic [1:0] round_next;
  logic [1:0] strike_next;

  // Taps 8,6,5,4; a non-zero seed can never decay to the all-zero lockup state
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Two conditional subtractions fold the 0..7 draw into 0..n-1 since n >= 3
  assign gen_num = 3'd3 + {1'b0, lfsr[1:0]};
  assign gen_t0  = lfsr[6:4];
  assign gen_t1  = (gen_t0 >= gen_num) ? gen_t0 - gen_num : gen_t0;
  assign gen_tgt = (gen_t1 >= gen_num) ? gen_t1 - gen_num : gen_t1;

  assign pos_bit     = 6'b000001 << wire_pos;
  assign pos_valid   = wire_pos < wire_num;
  assign pos_cut     = |(cut_mask & pos_bit);
  assign in_wire     = playing_state_in == WIRE;
  assign select_hit  = strobe && (button == SELECT);
  assign round_next  = round_cnt + 2'd1;
  assign strike_next = strikes + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED;
      wire_num     <= 3'd3;
      target_wire  <= 3'd0;
      cut_mask     <= 6'd0;
      strikes      <= 2'd0;
      round_cnt    <= 2'd0;
      strike_pulse <= 1'b0;
      wire_cleared <= 1'b0;
      wire_failed  <= 1'b0;
    end else begin
      lfsr         <= {lfsr[6:0], lfsr_fb};
      strike_pulse <= 1'b0;
      // Leaving WIRE wins over any press in the same cycle
      if (state != IDLE && !in_wire) begin
        state        <= IDLE;
        cut_mask     <= 6'd0;
        strikes      <= 2'd0;
        round_cnt    <= 2'd0;
        wire_cleared <= 1'b0;
        wire_failed  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cut_mask     <= 6'd0;
            strikes      <= 2'd0;
            round_cnt    <= 2'd0;
            wire_cleared <= 1'b0;
            wire_failed  <= 1'b0;
            if (in_wire) state <= GEN;
          end
          GEN: begin
            wire_num    <= gen_num;
            target_wire <= gen_tgt;
            cut_mask    <= 6'd0;
            state       <= ARMED;
          end
          ARMED: begin
            if (select_hit && pos_valid && !pos_cut) begin
              cut_mask <= cut_mask | pos_bit;
              if (wire_pos == target_wire) begin
                round_cnt <= round_next;
                if (round_next == ROUNDS_W) begin
                  state        <= DONE;
                  wire_cleared <= 1'b1;
                end else begin
                  state <= GEN;
                end
              end else begin
                strikes      <= strike_next;
                strike_pulse <= 1'b1;
                if (strike_next == STRIKES_W) begin
                  state       <= FAIL;
                  wire_failed <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t07_wire_game_ctrl.sv
// Self-checking bench for t07_wire_game_ctrl: hand-computed vector table,
// directed multi-cycle sequences and a randomized run against a rule-level model.
module tb_t07_wire_game_ctrl;

  localparam int         ROUNDS      = 2;
  localparam int         MAX_STRIKES = 3;
  localparam logic [7:0] SEED        = 8'hA5;
  localparam logic [2:0] WIRE        = 3'b010;
  localparam logic [5:0] SEL         = 6'b000001;

  localparam int P_IDLE  = 0;
  localparam int P_GEN   = 1;
  localparam int P_ARMED = 2;
  localparam int P_DONE  = 3;
  localparam int P_FAIL  = 4;

  typedef struct packed {
    logic [2:0] num;
    logic [2:0] tgt;
    logic [5:0] mask;
    logic [1:0] str;
    logic [1:0] rnd;
    logic       pulse;
    logic       clr;
    logic       fail;
  } outs_t;

  typedef struct {
    bit         rst;
    logic [2:0] ps;
    bit         strobe;
    logic [5:0] button;
    logic [2:0] pos;
    outs_t      exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] playing_state_in;
  logic       strobe;
  logic [5:0] button;
  logic [2:0] wire_pos;
  logic [2:0] wire_num;
  logic [2:0] target_wire;
  logic [5:0] cut_mask;
  logic [1:0] strikes;
  logic [1:0] round_cnt;
  logic       strike_pulse;
  logic       wire_cleared;
  logic       wire_failed;

  int compared = 0;
  int mismatched = 0;

  int         m_phase;
  logic [7:0] m_lfsr;
  logic [2:0] m_num;
  logic [2:0] m_tgt;
  logic [5:0] m_mask;
  logic [1:0] m_str;
  logic [1:0] m_rnd;
  logic       m_pulse;
  logic       m_clr;
  logic       m_fail;

  t07_wire_game_ctrl #(.ROUNDS(ROUNDS), .MAX_STRIKES(MAX_STRIKES), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .playing_state_in(playing_state_in), .strobe(strobe),
    .button(button), .wire_pos(wire_pos), .wire_num(wire_num), .target_wire(target_wire),
    .cut_mask(cut_mask), .strikes(strikes), .round_cnt(round_cnt),
    .strike_pulse(strike_pulse), .wire_cleared(wire_cleared), .wire_failed(wire_failed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mkOut(logic [2:0] n, logic [2:0] t, logic [5:0] m, logic [1:0] s,
                                  logic [1:0] r, logic p, logic c, logic f);
    outs_t o;
    o.num = n; o.tgt = t; o.mask = m; o.str = s; o.rnd = r; o.pulse = p; o.clr = c; o.fail = f;
    return o;
  endfunction

  function automatic vec_t mkVec(bit r, logic [2:0] ps, bit s, logic [5:0] b, logic [2:0] p, outs_t e);
    vec_t v;
    v.rst = r; v.ps = ps; v.strobe = s; v.button = b; v.pos = p; v.exp = e;
    return v;
  endfunction

  function automatic outs_t modelOuts();
    return mkOut(m_num, m_tgt, m_mask, m_str, m_rnd, m_pulse, m_clr, m_fail);
  endfunction

  function automatic void modelClear();
    m_mask = '0; m_str = '0; m_rnd = '0; m_clr = 0; m_fail = 0;
  endfunction

  // Game rules stated directly: parity feedback, modulo target, counters
  function automatic void modelStep(bit r, logic [2:0] ps, bit s, logic [5:0] b, logic [2:0] p);
    int cur, n, t;
    if (r) begin
      m_phase = P_IDLE; m_lfsr = SEED; m_num = 3'd3; m_tgt = 3'd0; m_pulse = 0;
      modelClear();
      return;
    end
    cur = int'(m_lfsr);
    m_pulse = 0;
    if (m_phase != P_IDLE && ps != WIRE) begin
      m_phase = P_IDLE;
      modelClear();
    end else begin
      case (m_phase)
        P_IDLE: begin
          modelClear();
          if (ps == WIRE) m_phase = P_GEN;
        end
        P_GEN: begin
          n = 3 + cur % 4;
          t = ((cur / 16) % 8) % n;
          m_num = 3'(n); m_tgt = 3'(t); m_mask = '0;
          m_phase = P_ARMED;
        end
        P_ARMED: begin
          if (s && b == SEL && p < m_num && !m_mask[p]) begin
            m_mask[p] = 1'b1;
            if (p == m_tgt) begin
              m_rnd = m_rnd + 2'd1;
              if (int'(m_rnd) == ROUNDS) begin m_phase = P_DONE; m_clr = 1; end
              else m_phase = P_GEN;
            end else begin
              m_str = m_str + 2'd1;
              m_pulse = 1;
              if (int'(m_str) == MAX_STRIKES) begin m_phase = P_FAIL; m_fail = 1; end
            end
          end
        end
        default: ;
      endcase
    end
    m_lfsr = 8'(((cur * 2) % 256) + ($countones(cur & 'hB8) % 2));
  endfunction

  task automatic applyStimulus(bit r, logic [2:0] ps, bit s, logic [5:0] b, logic [2:0] p);
    rst = r; playing_state_in = ps; strobe = s; button = b; wire_pos = p;
    @(posedge clk);
    modelStep(r, ps, s, b, p);
    #1;
  endtask

  task automatic checkOutput(string name, outs_t exp);
    outs_t act;
    act = mkOut(wire_num, target_wire, cut_mask, strikes, round_cnt, strike_pulse, wire_cleared, wire_failed);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got num=%0d tgt=%0d mask=%b str=%0d rnd=%0d pulse=%b clr=%b fail=%b, want num=%0d tgt=%0d mask=%b str=%0d rnd=%0d pulse=%b clr=%b fail=%b",
               name, act.num, act.tgt, act.mask, act.str, act.rnd, act.pulse, act.clr, act.fail,
               exp.num, exp.tgt, exp.mask, exp.str, exp.rnd, exp.pulse, exp.clr, exp.fail);
    end
  endtask

  task automatic checkValue(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic enterArmed(string name);
    applyStimulus(0, WIRE, 0, 6'd0, 3'd0);
    applyStimulus(0, WIRE, 0, 6'd0, 3'd0);
    checkOutput(name, modelOuts());
    checkValue({name, "_range"},
               int'(wire_num >= 3'd3 && wire_num <= 3'd6 && target_wire < wire_num && cut_mask == 6'd0), 1);
  endtask

  // Prefer an uncut wrong wire; fall back to the target when none is left
  function automatic logic [2:0] pickWrong();
    for (int i = 0; i < int'(m_num); i++)
      if (3'(i) != m_tgt && !m_mask[i]) return 3'(i);
    return m_tgt;
  endfunction

  vec_t vecs[12];
  int   pulses;

  initial begin
    rst = 1'b1; playing_state_in = 3'd0; strobe = 1'b0; button = 6'd0; wire_pos = 3'd0;

    vecs[0]  = mkVec(1, 3'd0, 0, 6'd0, 3'd0, mkOut(3, 0, 6'b000000, 0, 0, 0, 0, 0));
    vecs[1]  = mkVec(0, WIRE, 0, 6'd0, 3'd0, mkOut(3, 0, 6'b000000, 0, 0, 0, 0, 0));
    vecs[2]  = mkVec(0, WIRE, 0, 6'd0, 3'd0, mkOut(5, 4, 6'b000000, 0, 0, 0, 0, 0));
    vecs[3]  = mkVec(0, WIRE, 1, SEL,  3'd1, mkOut(5, 4, 6'b000010, 1, 0, 1, 0, 0));
    vecs[4]  = mkVec(0, WIRE, 1, SEL,  3'd1, mkOut(5, 4, 6'b000010, 1, 0, 0, 0, 0));
    vecs[5]  = mkVec(0, WIRE, 1, 6'b000100, 3'd2, mkOut(5, 4, 6'b000010, 1, 0, 0, 0, 0));
    vecs[6]  = mkVec(0, WIRE, 1, SEL,  3'd6, mkOut(5, 4, 6'b000010, 1, 0, 0, 0, 0));
    vecs[7]  = mkVec(0, WIRE, 1, SEL,  3'd4, mkOut(5, 4, 6'b010010, 1, 1, 0, 0, 0));
    vecs[8]  = mkVec(0, WIRE, 0, 6'd0, 3'd0, mkOut(6, 2, 6'b000000, 1, 1, 0, 0, 0));
    vecs[9]  = mkVec(0, WIRE, 1, SEL,  3'd2, mkOut(6, 2, 6'b000100, 1, 2, 0, 1, 0));
    vecs[10] = mkVec(0, WIRE, 0, 6'd0, 3'd0, mkOut(6, 2, 6'b000100, 1, 2, 0, 1, 0));
    vecs[11] = mkVec(0, 3'd0, 0, 6'd0, 3'd0, mkOut(6, 2, 6'b000000, 0, 0, 0, 0, 0));

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ps, vecs[i].strobe, vecs[i].button, vecs[i].pos);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Three wrong cuts end the game, each strike a single-cycle pulse
    enterArmed("fail_gen");
    pulses = 0;
    for (int k = 0; k < 40 && m_phase != P_FAIL; k++) begin
      applyStimulus(0, WIRE, 1, SEL, pickWrong());
      checkOutput("fail_press", modelOuts());
      if (strike_pulse) pulses++;
      applyStimulus(0, WIRE, 0, 6'd0, 3'd0);
      checkOutput("fail_gap", modelOuts());
      if (strike_pulse) pulses++;
    end
    checkValue("fail_strikes", int'(strikes), MAX_STRIKES);
    checkValue("fail_flag", int'(wire_failed), 1);
    checkValue("fail_pulses", pulses, MAX_STRIKES);
    applyStimulus(0, WIRE, 0, 6'd0, 3'd0);
    checkValue("fail_held", int'(wire_failed), 1);
    applyStimulus(0, 3'd0, 0, 6'd0, 3'd0);
    checkOutput("fail_exit", mkOut(m_num, m_tgt, 6'd0, 0, 0, 0, 0, 0));

    // Abort with two strikes; a press in the exit cycle is dropped
    enterArmed("abort_gen");
    for (int k = 0; k < 20 && m_str != 2'd2; k++) begin
      applyStimulus(0, WIRE, 1, SEL, pickWrong());
      checkOutput("abort_press", modelOuts());
      applyStimulus(0, WIRE, 0, 6'd0, 3'd0);
    end
    checkValue("abort_pre_strikes", int'(strikes), 2);
    applyStimulus(0, 3'd0, 1, SEL, pickWrong());
    checkOutput("abort_exit", mkOut(m_num, m_tgt, 6'd0, 0, 0, 0, 0, 0));
    enterArmed("abort_reenter");

    // Reset wins over a correct press in the same cycle
    applyStimulus(1, WIRE, 1, SEL, m_tgt);
    checkOutput("reset_armed", mkOut(3, 0, 6'd0, 0, 0, 0, 0, 0));

    for (int c = 0; c < 3000; c++) begin
      bit         r, s;
      logic [2:0] ps, p;
      logic [5:0] b;
      r  = ($urandom_range(0, 99) == 0);
      ps = ($urandom_range(0, 9) != 0) ? WIRE : 3'($urandom_range(0, 7));
      s  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1:    b = SEL;
        2:       b = 6'b000001 << $urandom_range(0, 5);
        default: b = 6'($urandom);
      endcase
      p = ($urandom_range(0, 2) == 0) ? m_tgt : 3'($urandom_range(0, 7));
      applyStimulus(r, ps, s, b, p);
      checkOutput("random", modelOuts());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/t07_wire_game_ctrl.md
Name: t07_wire_game_ctrl

Overview:
Round sequencer for the wire mini-game. When the top-level playing state enters WIRE, it draws a random wire count and target wire, then judges each SELECT press against the current cursor position from the wire locator. It counts strikes and cleared rounds, and raises wire_cleared or wire_failed. It feeds wire_num and wire_cleared to the locator and the display, and takes wire_pos back from the locator.

Parameters:
ROUNDS, 2, target cuts needed to win (1-3)
MAX_STRIKES, 3, wrong cuts that cause a fail (1-3)
SEED, 8'hA5, LFSR reset value (must be non-zero)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
playing_state_in  input  3  mode select; WIRE = 3'b010
strobe  input  1  one-cycle button-valid pulse
button  input  6  one-hot button; SELECT = 6'b000001, others ignored
wire_pos  input  3  cursor index from the locator
wire_num  output  3  wires in the current round (3-6)
target_wire  output  3  correct wire index (0..wire_num-1)
cut_mask  output  6  bit i set = wire i already cut this round
strikes  output  2  wrong cuts so far
round_cnt  output  2  rounds cleared so far
strike_pulse  output  1  one-cycle pulse on each wrong cut
wire_cleared  output  1  game won; held
wire_failed  output  1  game lost; held

Behaviour:
- Clock is clk only; rst is synchronous, active-high and samples on posedge clk.
- Reset values: state=IDLE, lfsr=SEED, wire_num=3, target_wire=0, cut_mask=0, strikes=0, round_cnt=0, strike_pulse=0, wire_cleared=0, wire_failed=0.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Shifts every cycle in all states, including outside WIRE; shift-left, feedback into bit 0.
  - Never reaches zero.
- States are IDLE, GEN, ARMED, DONE and FAIL. All outputs are registered.
- IDLE:
  - Clears cut_mask, strikes, round_cnt and both flags.
  - Moves to GEN on the first cycle that playing_state_in==WIRE.
- GEN (exactly 1 cycle):
  - wire_num <= 3 + lfsr[1:0].
  - t = lfsr[6:4]. If t >= n, then t -= n; if still t >= n, then t -= n. Here n is the newly computed count.
  - target_wire <= t; cut_mask <= 0.
  - Next state is ARMED.
- ARMED:
  - Acts only when strobe && button==SELECT; any other strobe/button combination is ignored.
  - wire_pos >= wire_num: ignored (defensive).
  - cut_mask[wire_pos] already 1: ignored, no strike.
  - Otherwise cut_mask[wire_pos] <= 1, then:
    - wire_pos==target_wire: round_cnt += 1. If the new value is ROUNDS, go to DONE; otherwise go to GEN, with strikes kept.
    - wire_pos!=target_wire: strikes += 1 and strike_pulse=1 for one cycle. If the new value is MAX_STRIKES, go to FAIL; otherwise stay in ARMED.
- DONE: wire_cleared=1.
- FAIL: wire_failed=1.
- Leaving WIRE:
  - From GEN or ARMED, playing_state_in != WIRE goes to IDLE next cycle. This aborts the round and clears all counters.
  - DONE and FAIL also return to IDLE when playing_state_in != WIRE. Their flags stay high until that exit so the top level can read them.
- Latency: a SELECT strobe in cycle N updates cut_mask, strikes, round_cnt and the state at edge N+1. wire_cleared and wire_failed assert on that same edge.
- Simultaneous events:
  - rst has priority over everything.
  - A state exit has priority over a SELECT in the same cycle; that press is dropped.
- Widths:
  - strikes and round_cnt saturate at their terminal value; no wrap is possible because the state leaves ARMED.
  - wire_num is never 0, so the locator's wire_num-1 is safe.

Test Plan:
- Reset with SEED=8'hA5, then hold playing_state_in=3'b010. Required: GEN occurs one cycle after the state enters WIRE; wire_num is in 3..6; target_wire < wire_num; cut_mask=0.
- In ARMED, drive wire_pos=target_wire and pulse strobe with button=6'b000001, twice across rounds (ROUNDS=2). Required: round_cnt goes 1 then 2; a new GEN runs after round 1; wire_cleared=1 on the edge after the second press.
- Select a non-target wire three times at distinct positions. Required: strikes goes 1, 2, 3; strike_pulse fires 3 single-cycle pulses; wire_failed=1 after the third; cut_mask has 3 bits set.
- Select the same wrong wire twice, and drive strobe with button=6'b000100. Required: strikes=1 only; cut_mask unchanged by the repeat and by the RIGHT press.
- Mid-round with strikes=2, set playing_state_in=3'b000. Required: IDLE on the next cycle; strikes, round_cnt and cut_mask all 0. Re-entering WIRE draws a fresh round.
- Assert rst in ARMED together with a SELECT strobe on the target wire. Required: all outputs return to reset values and round_cnt stays 0.
